// File: rtl/fifo_sinc.sv
// fifo_sinc - synchronous FIFO used on both sides of the arbitro.
//
// A write is accepted when push is high and the FIFO is not full. A read is
// accepted when pop is high and the FIFO is not empty. The read path is
// registered: a popped word appears on data_out one cycle after the pop,
// and valid_out marks that cycle.
//
// Optional build macro: FIFO_SINC_ERR_EN
//   defined   : error is a sticky flag, set by push-while-full or
//               pop-while-empty and cleared only by reset
//   undefined : error is tied to 0
//   The port list is the same in both builds.
//
// Parameters
//   FIFO_WORD_SIZE   data width; the top two bits carry the destination port
//   FIFO_DEPTH_LOG2  log2 of depth (DEPTH = 2**FIFO_DEPTH_LOG2)
//
// Ports
//   clk           clock; all logic runs on its rising edge
//   reset         synchronous, active-high
//   data_in       write data
//   push          write request
//   pop           read request
//   umbral_alto   almost-full threshold (1..DEPTH)
//   umbral_bajo   almost-empty threshold (0..DEPTH-1)
//   data_out      registered read data
//   valid_out     data_out holds a word popped on the previous cycle
//   empty         count == 0
//   full          count == DEPTH
//   almost_full   count >= umbral_alto
//   almost_empty  count <= umbral_bajo
//   count         current occupancy, 0..DEPTH
//   error         sticky overflow/underflow flag (see macro above)

module fifo_sinc #(
  parameter int FIFO_WORD_SIZE  = 10,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [FIFO_WORD_SIZE-1:0]  data_in,
  input  logic                       push,
  input  logic                       pop,
  input  logic [FIFO_DEPTH_LOG2:0]   umbral_alto,
  input  logic [FIFO_DEPTH_LOG2:0]   umbral_bajo,
  output logic [FIFO_WORD_SIZE-1:0]  data_out,
  output logic                       valid_out,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [FIFO_DEPTH_LOG2:0]   count,
  output logic                       error
);

  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_CNT = DEPTH[FIFO_DEPTH_LOG2:0];

  logic [FIFO_WORD_SIZE-1:0]  mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic                       wr_acc;
  logic                       rd_acc;

  // All flags come straight from the registered count, so a simultaneous
  // push/pop never sees the other side's effect in the same cycle.
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_CNT);
  assign almost_full  = (count >= umbral_alto);
  assign almost_empty = (count <= umbral_bajo);

  assign wr_acc = push & ~full;
  assign rd_acc = pop & ~empty;

  // Storage is not reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (wr_acc) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // A read of the slot being written this cycle returns the old word,
  // because mem is sampled before the write lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (rd_acc) begin
      rd_ptr    <= rd_ptr + 1'b1;
      data_out  <= mem[rd_ptr];
      valid_out <= 1'b1;
    end else begin
      valid_out <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_SINC_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      error <= 1'b0;
    end else if ((push & full) | (pop & empty)) begin
      error <= 1'b1;
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sinc.sv
module tb_fifo_sinc;

  localparam int W = 10;
  localparam int L = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         push;
  logic         pop;
  logic [L:0]   umbral_alto;
  logic [L:0]   umbral_bajo;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         empty;
  logic         full;
  logic         almost_full;
  logic         almost_empty;
  logic [L:0]   count;
  logic         error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] model_q[$];
  logic [W-1:0] exp_q[$];

`ifdef FIFO_SINC_ERR_EN
  localparam logic ERR_ON_FAULT = 1'b1;
`else
  localparam logic ERR_ON_FAULT = 1'b0;
`endif

  fifo_sinc #(.FIFO_WORD_SIZE(W), .FIFO_DEPTH_LOG2(L)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .push         (push),
    .pop          (pop),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every word presented on valid_out is matched against the scoreboard.
  always @(negedge clk) begin
    if (!reset && valid_out === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got 0x%0h, expected no output", data_out);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          n_fail++;
          $display("FAIL sb_data: got 0x%0h, expected 0x%0h", data_out, e);
        end
      end
    end
  end

  // One clock of stimulus; the reference queue decides acceptance from the
  // occupancy at the start of the cycle.
  task automatic cyc(input logic p, input logic q, input logic [W-1:0] d);
    bit was_full, was_empty;
    was_full  = (model_q.size() == 8);
    was_empty = (model_q.size() == 0);
    push = p; pop = q; data_in = d;
    if (q && !was_empty) exp_q.push_back(model_q.pop_front());
    if (p && !was_full) model_q.push_back(d);
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic do_reset(input int cycles, input logic q);
    reset = 1'b1; pop = q;
    repeat (cycles) begin @(posedge clk); #1; end
    reset = 1'b0; pop = 1'b0;
    model_q.delete();
  endtask

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
    umbral_alto = 4'd6; umbral_bajo = 4'd2;
    @(posedge clk); #1;

    // Reset state
    do_reset(2, 1'b0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(valid_out), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_error", 32'(error), 0);
    check("rst_aempty", 32'(almost_empty), 1);
    check("rst_afull", 32'(almost_full), 0);

    // Fill 0x001..0x008
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, W'(i));
      check("fill_count", 32'(count), 32'(i));
      check("fill_afull", 32'(almost_full), (i >= 6) ? 1 : 0);
      check("fill_aempty", 32'(almost_empty), (i <= 2) ? 1 : 0);
      check("fill_full", 32'(full), (i == 8) ? 1 : 0);
    end

    // Overflow
    cyc(1'b1, 1'b0, 10'h3FF);
    check("ovf_count", 32'(count), 8);
    check("ovf_error", 32'(error), 32'(ERR_ON_FAULT));

    // Drain: each word one cycle after its pop
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, '0);
      check("drain_valid", 32'(valid_out), 1);
      check("drain_data", 32'(data_out), 32'(i));
      check("drain_count", 32'(count), 32'(8 - i));
    end
    check("drain_empty", 32'(empty), 1);
    cyc(1'b0, 1'b0, '0);
    check("idle_valid", 32'(valid_out), 0);
    check("hold_data", 32'(data_out), 32'h008);

    // Push and pop on empty: only the push lands
    cyc(1'b1, 1'b1, 10'h2AA);
    check("pp_empty_count", 32'(count), 1);
    check("pp_empty_valid", 32'(valid_out), 0);

    // Push and pop on full: only the pop lands
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, W'(10'h010 + i));
    check("pp_full_pre", 32'(full), 1);
    cyc(1'b1, 1'b1, 10'h155);
    check("pp_full_count", 32'(count), 7);
    check("pp_full_data", 32'(data_out), 32'h2AA);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, '0);
    check("pp_full_drained", 32'(count), 0);

    // Push and pop at count 3
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, W'(10'h0A0 + i));
    cyc(1'b1, 1'b1, 10'h0B0);
    check("pp_mid_count", 32'(count), 3);
    check("pp_mid_data", 32'(data_out), 32'h0A0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, '0);
    check("pp_mid_last", 32'(data_out), 32'h0B0);

    // Wrap-around streaming
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, W'(10'h100 + i));
    for (int i = 4; i < 24; i++) begin
      cyc(1'b1, 1'b1, W'(10'h100 + i));
      check("wrap_count", 32'(count), 4);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, '0);
    check("wrap_last", 32'(data_out), 32'h117);
    check("wrap_empty", 32'(empty), 1);

    // Threshold change reflects immediately
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, W'(10'h200 + i));
    check("thr_af_before", 32'(almost_full), 0);
    umbral_alto = 4'd5; #1;
    check("thr_af_after", 32'(almost_full), 1);
    umbral_bajo = 4'd5; #1;
    check("thr_ae_after", 32'(almost_empty), 1);
    umbral_alto = 4'd6; umbral_bajo = 4'd2; #1;

    // Reset mid-burst with pop asserted
    check("mid_pre_count", 32'(count), 5);
    do_reset(1, 1'b1);
    check("mid_count", 32'(count), 0);
    check("mid_empty", 32'(empty), 1);
    check("mid_valid", 32'(valid_out), 0);
    check("mid_error", 32'(error), 0);
    cyc(1'b0, 1'b0, '0);

    // Contents were discarded: new data comes out first
    cyc(1'b1, 1'b0, 10'h321);
    cyc(1'b0, 1'b1, '0);
    check("post_rst_data", 32'(data_out), 32'h321);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    check("sb_leftover", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
